param_fifo: RTL and testbench

//  Parametrised synchronous FIFO; next generation of the team's 4x4 FIFO. Adds:
//  - generic width and depth (depth need not be a power of two)
//  - fill level, almost-full/almost-empty thresholds
//  - synchronous flush and sticky overflow/underflow error flags

---
 rtl/param_fifo_pkg.sv | 18 +
 rtl/param_fifo_if.sv | 34 +++
 rtl/param_fifo_wrap_ctr.sv | 25 ++
 rtl/param_fifo.sv | 116 +++++++++++
 tb/tb_param_fifo.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/param_fifo_pkg.sv
// Shared sizing helpers and pointer arithmetic for the parametrised FIFO.
// Pointers run 0..DEPTH-1, so DEPTH does not have to be a power of two.
package param_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // The level counter must be able to hold DEPTH itself, hence DEPTH+1.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer-side bundle of the FIFO; master drives requests, slave is the FIFO.
interface param_fifo_if
    import param_fifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int LW = lvl_w(DEPTH)
) ();

    logic             flush;
    logic             clr_err;
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic [WIDTH-1:0] read_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, clr_err, write_en, write_data, read_en,
        input  read_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, write_en, write_data, read_en,
        output read_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/param_fifo_wrap_ctr.sv
// Pointer counter that wraps DEPTH-1 -> 0; sync clear has priority over enable.
module fifo_wrap_ctr
    import param_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= PW'(next_ptr(32'(cnt), 32'(DEPTH)));
    end

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with show-ahead read, empty bypass, flush and sticky errors.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input logic          clk,
    input logic          rstN,
    param_fifo_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf_q;
    logic             unf_q;

    // Flags come from the registered level only; pointers alone cannot tell full from empty.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_acc  = 1'b0;
        rd_acc  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!bus.flush) begin
            wr_acc  = bus.write_en & (!full | bus.read_en);
            rd_acc  = bus.read_en & (!empty | bus.write_en);
            ovf_set = bus.write_en & full & !bus.read_en;
            unf_set = bus.read_en & empty & !bus.write_en;
        end
    end

    fifo_wrap_ctr #(.DEPTH(DEPTH)) u_wr_ctr (
        .clk  (clk),
        .rstN (rstN),
        .clr  (bus.flush),
        .en   (wr_acc),
        .cnt  (wr_ptr)
    );

    fifo_wrap_ctr #(.DEPTH(DEPTH)) u_rd_ctr (
        .clk  (clk),
        .rstN (rstN),
        .clr  (bus.flush),
        .en   (rd_acc),
        .cnt  (rd_ptr)
    );

    // NOTE: storage is deliberately not reset; level gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.write_data;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            level_q <= '0;
        else if (bus.flush)
            level_q <= '0;
        else if (wr_acc && !rd_acc)
            level_q <= level_q + LW'(1);
        else if (rd_acc && !wr_acc)
            level_q <= level_q - LW'(1);
    end

    // A new error in the clr_err cycle wins; flush leaves the flags alone.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (bus.clr_err)
                ovf_q <= 1'b0;
            if (unf_set)
                unf_q <= 1'b1;
            else if (bus.clr_err)
                unf_q <= 1'b0;
        end
    end

    // On empty, an accepted read can only be the same-cycle bypass of write_data.
    always_comb begin
        bus.read_data = '0;
        if (!empty)
            bus.read_data = mem[rd_ptr];
        else if (rd_acc)
            bus.read_data = bus.write_data;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= LW'(AF_THRESH));
    assign bus.almost_empty = (level_q <= LW'(AE_THRESH));
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench: three FIFO sizes share stimulus; a queue model scores the selected one.
module tb_param_fifo;

    logic       clk;
    logic       rstN;
    logic       flush;
    logic       clr_err;
    logic       write_en;
    logic [3:0] write_data;
    logic       read_en;

    int n_checks;
    int n_fail;
    int sel;
    int cur_depth;

    logic [3:0] q[$];
    logic       m_ovf;
    logic       m_unf;

    logic [3:0] o_rd;
    logic [2:0] o_lvl;
    logic [5:0] o_flg;

    param_fifo_if #(.WIDTH(4), .DEPTH(5)) bus5 ();
    param_fifo_if #(.WIDTH(4), .DEPTH(4)) bus4 ();
    param_fifo_if #(.WIDTH(4), .DEPTH(3)) bus3 ();

    assign bus5.flush = flush;  assign bus5.clr_err = clr_err;  assign bus5.write_en = write_en;
    assign bus5.write_data = write_data;  assign bus5.read_en = read_en;
    assign bus4.flush = flush;  assign bus4.clr_err = clr_err;  assign bus4.write_en = write_en;
    assign bus4.write_data = write_data;  assign bus4.read_en = read_en;
    assign bus3.flush = flush;  assign bus3.clr_err = clr_err;  assign bus3.write_en = write_en;
    assign bus3.write_data = write_data;  assign bus3.read_en = read_en;

    param_fifo #(.WIDTH(4), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) u_dut5 (
        .clk(clk), .rstN(rstN), .bus(bus5.slave));
    param_fifo #(.WIDTH(4), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) u_dut4 (
        .clk(clk), .rstN(rstN), .bus(bus4.slave));
    param_fifo #(.WIDTH(4), .DEPTH(3), .AF_THRESH(3), .AE_THRESH(1)) u_dut3 (
        .clk(clk), .rstN(rstN), .bus(bus3.slave));

    // Flag vector order: {full, empty, almost_full, almost_empty, overflow, underflow}
    always_comb begin
        o_rd  = bus5.read_data;
        o_lvl = bus5.level;
        o_flg = {bus5.full, bus5.empty, bus5.almost_full, bus5.almost_empty, bus5.overflow, bus5.underflow};
        if (sel == 4) begin
            o_rd  = bus4.read_data;
            o_lvl = bus4.level;
            o_flg = {bus4.full, bus4.empty, bus4.almost_full, bus4.almost_empty, bus4.overflow, bus4.underflow};
        end else if (sel == 3) begin
            o_rd  = bus3.read_data;
            o_lvl = {1'b0, bus3.level};
            o_flg = {bus3.full, bus3.empty, bus3.almost_full, bus3.almost_empty, bus3.overflow, bus3.underflow};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int depth);
        @(negedge clk);
        rstN = 1'b0;
        {write_en, read_en, flush, clr_err} = 4'b0000;
        write_data = 4'h0;
        sel = depth;
        cur_depth = depth;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    // Drive one cycle, score read_data on reads, then advance the reference model.
    task automatic step(input string tag, input logic we, input logic [3:0] wd,
                        input logic re, input logic fl, input logic ce);
        int         sz;
        bit         mf, me, wa, ra, nov, nun;
        logic [3:0] exp_rd;
        @(negedge clk);
        write_en = we; write_data = wd; read_en = re; flush = fl; clr_err = ce;
        sz = q.size();
        mf = (sz == cur_depth);
        me = (sz == 0);
        exp_rd = me ? ((we && re && !fl) ? wd : 4'h0) : q[0];
        #1;
        if (re) check({tag, ".read_data"}, 32'(o_rd), 32'(exp_rd));
        nov = 1'b0;
        nun = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            wa  = we && (!mf || re);
            ra  = re && (!me || we);
            nov = we && mf && !re;
            nun = re && me && !we;
            if (ra && !me) void'(q.pop_front());
            if (wa && !(ra && me)) q.push_back(wd);
        end
        m_ovf = nov ? 1'b1 : (ce ? 1'b0 : m_ovf);
        m_unf = nun ? 1'b1 : (ce ? 1'b0 : m_unf);
        @(posedge clk);
        #1;
        {write_en, read_en, flush, clr_err} = 4'b0000;
        write_data = 4'h0;
    endtask

    task automatic check_state(input string tag);
        int         sz;
        logic [5:0] exp_flg;
        sz = q.size();
        exp_flg = {sz == cur_depth, sz == 0, sz >= 3, sz <= 1, m_ovf, m_unf};
        check({tag, ".level"}, 32'(o_lvl), 32'(sz));
        check({tag, ".flags"}, 32'(o_flg), 32'(exp_flg));
    endtask

    typedef struct packed {
        logic [3:0] ctl;   // {write_en, read_en, flush, clr_err}
        logic [3:0] wd;
        logic [2:0] lvl;
        logic [5:0] flg;
    } vec_t;

    vec_t tbl [16];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstN     = 1'b1;
        {write_en, read_en, flush, clr_err} = 4'b0000;
        write_data = 4'h0;

        tbl[0]  = '{4'b1000, 4'h1, 3'd1, 6'b000100};
        tbl[1]  = '{4'b1000, 4'h2, 3'd2, 6'b000000};
        tbl[2]  = '{4'b1000, 4'h3, 3'd3, 6'b001000};
        tbl[3]  = '{4'b1000, 4'h4, 3'd4, 6'b001000};
        tbl[4]  = '{4'b1000, 4'h5, 3'd5, 6'b101000};
        tbl[5]  = '{4'b1000, 4'h6, 3'd5, 6'b101010};
        tbl[6]  = '{4'b0001, 4'h0, 3'd5, 6'b101000};
        tbl[7]  = '{4'b0100, 4'h0, 3'd4, 6'b001000};
        tbl[8]  = '{4'b0100, 4'h0, 3'd3, 6'b001000};
        tbl[9]  = '{4'b0100, 4'h0, 3'd2, 6'b000000};
        tbl[10] = '{4'b0100, 4'h0, 3'd1, 6'b000100};
        tbl[11] = '{4'b0100, 4'h0, 3'd0, 6'b010100};
        tbl[12] = '{4'b0100, 4'h0, 3'd0, 6'b010101};
        tbl[13] = '{4'b0101, 4'h0, 3'd0, 6'b010101};
        tbl[14] = '{4'b0001, 4'h0, 3'd0, 6'b010100};
        tbl[15] = '{4'b1100, 4'hA, 3'd0, 6'b010100};

        // DEPTH=5: reset state, fill to full, overflow, drain in order, underflow, bypass
        do_reset(5);
        #1;
        check("reset.level", 32'(o_lvl), 32'd0);
        check("reset.flags", 32'(o_flg), 32'(6'b010100));
        check("reset.read_data", 32'(o_rd), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), tbl[i].ctl[3], tbl[i].wd, tbl[i].ctl[2],
                 tbl[i].ctl[1], tbl[i].ctl[0]);
            check($sformatf("vec%0d.level", i), 32'(o_lvl), 32'(tbl[i].lvl));
            check($sformatf("vec%0d.flags", i), 32'(o_flg), 32'(tbl[i].flg));
        end

        // DEPTH=4: flush with a pending write, error flag survives, then a clean write
        do_reset(4);
        step("unf", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) step("fill4", 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        check_state("fill4");
        step("flush", 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
        check_state("flush");
        check("flush.level_zero", 32'(o_lvl), 32'd0);
        step("post_flush_wr", 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        check("post_flush.read_data", 32'(o_rd), 32'h7);
        step("post_flush_rd", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_state("post_flush_rd");

        // DEPTH=3: read+write while full keeps level and order
        do_reset(3);
        for (int i = 1; i <= 3; i++) step("fill3", 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        check_state("fill3");
        step("full_wr_rd", 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
        check_state("full_wr_rd");
        for (int i = 0; i < 3; i++) step("drain3", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_state("drain3");

        // DEPTH=3: ten interleaved write/read pairs exercise pointer wrap
        do_reset(3);
        step("wrap0", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) step("wrap", 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
        step("wrap_last", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_state("wrap_end");

        // Asynchronous reset mid-stream clears contents without waiting for an edge
        step("pre_rst1", 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        step("pre_rst2", 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        check_state("pre_rst");
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        check("async_rst.level", 32'(o_lvl), 32'd0);
        check("async_rst.empty", 32'(o_flg[4]), 32'd1);
        check("async_rst.read_data", 32'(o_rd), 32'd0);
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        step("after_rst", 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        step("after_rst_rd", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_state("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
